// File: rtl/openhw_ptwalk_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cvw
// Description : Shared constants and types for the SV39/SV48 page-table
//               walker: address widths, SATP mode encodings, PTE field
//               positions and the walker state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package cvw;

    localparam int XLEN        = 64;
    localparam int PA_BITS     = 56;
    localparam int PPN_BITS    = 44;
    localparam int SVMODE_BITS = 4;

    localparam logic [SVMODE_BITS-1:0] SV39 = 4'd8;
    localparam logic [SVMODE_BITS-1:0] SV48 = 4'd9;

    // PTE field positions
    localparam int PTE_V        = 0;
    localparam int PTE_R        = 1;
    localparam int PTE_W        = 2;
    localparam int PTE_X        = 3;
    localparam int PTE_PPN_LSB  = 10;
    localparam int PTE_PPN_MSB  = 53;
    localparam int PTE_RSVD_LSB = 54;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } ptw_state_t;

endpackage
`default_nettype wire

// File: rtl/openhw_ptwalk_pte_check.sv
`default_nettype none
// ============================================================================
// Module      : openhw_pte_check
// Description : Combinational classification of one PTE fetched at a given
//               walk level. Reports whether the PTE is a leaf and whether it
//               raises a page fault (invalid encoding, reserved bits set,
//               misaligned superpage, or a pointer at level 0).
// Ports       : pte        in  64  PTE read from memory
//               level      in  2   level the PTE was fetched at
//               leaf       out 1   R or X set
//               page_fault out 1   PTE cannot be used for translation
// Revision    : 1.0 - initial release
// ============================================================================
module openhw_pte_check
    import cvw::*;
(
    input  logic [63:0] pte,
    input  logic [1:0]  level,
    output logic        leaf,
    output logic        page_fault
);

    logic [PPN_BITS-1:0] w_ppn;
    logic [PPN_BITS-1:0] w_align_mask;
    logic                w_invalid;
    logic                w_misaligned;
    logic                w_unused_flags;

    // U/G/A/D/RSW are checked by the TLB fault logic, not here
    assign w_unused_flags = ^pte[9:4];

    always_comb begin
        w_ppn = pte[PTE_PPN_MSB:PTE_PPN_LSB];
        // A superpage leaf at level L must have its low 9*L PPN bits clear
        case (level)
            2'd1:    w_align_mask = 44'h0000000_01FF;
            2'd2:    w_align_mask = 44'h0000003_FFFF;
            2'd3:    w_align_mask = 44'h0000_07FF_FFFF;
            default: w_align_mask = '0;
        endcase
        leaf         = pte[PTE_R] | pte[PTE_X];
        w_invalid    = ~pte[PTE_V]
                     | (~pte[PTE_R] & pte[PTE_W])
                     | (|pte[63:PTE_RSVD_LSB]);
        w_misaligned = leaf & (|(w_ppn & w_align_mask));
        page_fault   = w_invalid | w_misaligned | (~leaf & (level == 2'd0));
    end

endmodule
`default_nettype wire

// File: rtl/openhw_ptwalk.sv
`default_nettype none
// ============================================================================
// Module      : openhw_ptwalk
// Description : Hardware page-table walker for RV64 SV39/SV48. On a TLB miss
//               walks from SATP.PPN, one outstanding PTE read at a time, and
//               returns the leaf PTE and its level, or a page/access fault.
// Ports       : clk, reset (sync, active-high)
//               SATP_MODE, SATP_PPN          translation root
//               VAdr, SV39Mode,
//               UpperBitsUnequal             request VA and canonical check
//               Flush                        abort walk
//               WalkReq / WalkReady          request handshake
//               MemReq/MemAdr/MemGnt         PTE read request
//               MemRspValid/Data/Err         PTE read response
//               WalkDone, PTE, PageLevel,
//               PageFault, AccessFault       result
// Revision    : 1.0 - initial release
// ============================================================================
module openhw_ptwalk
    import cvw::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SVMODE_BITS-1:0] SATP_MODE,
    input  logic [PPN_BITS-1:0]    SATP_PPN,
    input  logic [XLEN-1:0]        VAdr,
    input  logic                   SV39Mode,
    input  logic                   UpperBitsUnequal,
    input  logic                   Flush,
    input  logic                   WalkReq,
    output logic                   WalkReady,
    output logic                   MemReq,
    output logic [PA_BITS-1:0]     MemAdr,
    input  logic                   MemGnt,
    input  logic                   MemRspValid,
    input  logic [63:0]            MemRspData,
    input  logic                   MemRspErr,
    output logic                   WalkDone,
    output logic [63:0]            PTE,
    output logic [1:0]             PageLevel,
    output logic                   PageFault,
    output logic                   AccessFault
);

    ptw_state_t          r_state;
    ptw_state_t          w_next_state;
    logic [1:0]          r_level;
    logic [PPN_BITS-1:0] r_ppn;
    logic [35:0]         r_vpn;      // VA[47:12]: the four 9-bit VPN fields
    logic [8:0]          w_vpn_sel;
    logic                w_walk_ok;
    logic                w_accept;
    logic                w_descend;
    logic                w_result;
    logic                w_pte_leaf;
    logic                w_pte_fault;
    logic                w_unused_va;

    // Canonical checking is upstream; only the VPN bits are kept
    assign w_unused_va = ^{VAdr[63:48], VAdr[11:0]};

    assign w_walk_ok = ((SATP_MODE == SV39) || (SATP_MODE == SV48)) & ~UpperBitsUnequal;

    always_comb begin
        case (r_level)
            2'd0:    w_vpn_sel = r_vpn[8:0];
            2'd1:    w_vpn_sel = r_vpn[17:9];
            2'd2:    w_vpn_sel = r_vpn[26:18];
            default: w_vpn_sel = r_vpn[35:27];
        endcase
    end

    assign MemAdr = {r_ppn, w_vpn_sel, 3'b000};

    openhw_pte_check u_pte_check (
        .pte        (MemRspData),
        .level      (r_level),
        .leaf       (w_pte_leaf),
        .page_fault (w_pte_fault)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        WalkReady    = 1'b0;
        MemReq       = 1'b0;
        WalkDone     = 1'b0;
        w_accept     = 1'b0;
        w_descend    = 1'b0;
        w_result     = 1'b0;
        case (r_state)
            S_IDLE: begin
                WalkReady = 1'b1;
                if (!Flush && WalkReq) begin
                    w_accept     = 1'b1;
                    w_next_state = w_walk_ok ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                MemReq = 1'b1;
                // A grant coinciding with Flush leaves a read in flight whose
                // response must be swallowed
                if (Flush) begin
                    w_next_state = MemGnt ? S_DRAIN : S_IDLE;
                end else if (MemGnt) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Flush) begin
                    w_next_state = MemRspValid ? S_IDLE : S_DRAIN;
                end else if (MemRspValid) begin
                    if (!MemRspErr && !w_pte_fault && !w_pte_leaf) begin
                        w_descend    = 1'b1;
                        w_next_state = S_REQ;
                    end else begin
                        w_result     = 1'b1;
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                if (MemRspValid) begin
                    w_next_state = S_IDLE;
                end
            end
            S_DONE: begin
                WalkDone     = ~Flush;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level     <= 2'd0;
            r_ppn       <= '0;
            r_vpn       <= '0;
            PTE         <= '0;
            PageLevel   <= 2'd0;
            PageFault   <= 1'b0;
            AccessFault <= 1'b0;
        end else begin
            if (w_accept) begin
                r_vpn       <= VAdr[47:12];
                r_level     <= SV39Mode ? 2'd2 : 2'd3;
                r_ppn       <= SATP_PPN;
                PTE         <= '0;
                PageLevel   <= 2'd0;
                PageFault   <= ~w_walk_ok;
                AccessFault <= 1'b0;
            end
            if (w_descend) begin
                r_ppn   <= MemRspData[PTE_PPN_MSB:PTE_PPN_LSB];
                r_level <= r_level - 2'd1;
            end
            if (w_result) begin
                AccessFault <= MemRspErr;
                PageFault   <= ~MemRspErr & w_pte_fault;
                if (!MemRspErr && !w_pte_fault) begin
                    PTE       <= MemRspData;
                    PageLevel <= r_level;
                end
            end
        end
    end

endmodule
`default_nettype wire
